signed_mac_acc: RTL and testbench
=================================

SIGNED_MAC_ACC -- requirements
Module: signed_mac_acc

Interface
REQ-001 SHALL have parameter LEN, default 4, number of products summed per result (legal 1..255).
REQ-002 SHALL have parameter ACC_W, default 16, accumulator/result width (legal 16..32).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair a/b valid.
REQ-006 SHALL have port in_ready  output  1  block accepts an operand pair this cycle.
REQ-007 SHALL have port a  input  8  signed two's-complement multiplicand.
REQ-008 SHALL have port b  input  8  signed two's-complement multiplier.
REQ-009 SHALL have port out_valid  output  1  acc_out/ovf hold a completed result.
REQ-010 SHALL have port out_ready  input  1  downstream consumes result this cycle.
REQ-011 SHALL have port acc_out  output  ACC_W  signed saturated sum of LEN products.
REQ-012 SHALL have port ovf  output  1  sticky: saturation occurred in current sum.
REQ-013 SHALL have port beat_cnt  output  8  operand pairs accepted in current sum.

Function
REQ-014 SHALL implement states IDLE (acc=0, no beats), ACCUM (1..LEN-1 beats taken), HOLD (result presented).
REQ-015 SHALL assert in_ready in IDLE and ACCUM, deassert in HOLD; in_ready SHALL not depend combinationally on in_valid.
REQ-016 SHALL accept a beat only on in_valid && in_ready at a rising edge; cycles with in_valid=0 are bubbles that change nothing.
REQ-017 SHALL form the full 16-bit signed product of a*b (range -16256..16384), sign-extended to ACC_W+1 bits; no truncation to 8 bits.
REQ-018 SHALL on each accepted beat update acc <= sat(acc + product) in the same edge (latency 1 cycle per beat, no pipeline bubble).
REQ-019 SHALL saturate to +(2^(ACC_W-1))-1 on positive overflow and -(2^(ACC_W-1)) on negative overflow, setting ovf=1; ovf stays 1 until the result is consumed or reset.
REQ-020 SHALL increment beat_cnt per accepted beat; IDLE->ACCUM on first beat; on the LEN-th beat go to HOLD (IDLE->HOLD directly when LEN=1).
REQ-021 SHALL assert out_valid in the cycle immediately after the LEN-th accepted beat and hold acc_out, ovf, beat_cnt=LEN stable while out_valid && !out_ready.
REQ-022 SHALL on out_valid && out_ready return to IDLE with acc=0, ovf=0, beat_cnt=0, out_valid=0 at that edge; no new beat is accepted in that same cycle.
REQ-023 SHALL ignore a, b, in_valid entirely while in HOLD.
REQ-024 SHALL keep acc_out driven with the running accumulator in IDLE/ACCUM (value meaningful only when out_valid=1).

Reset
REQ-025 SHALL on rst=1 at a rising edge force state=IDLE, acc_out=0, ovf=0, beat_cnt=0, out_valid=0, in_ready=1 next cycle, regardless of state.
REQ-026 SHALL give rst priority over any simultaneous beat or consume handshake; a partially accumulated sum is discarded.

Verification (LEN=4, ACC_W=16)
REQ-027 SHALL pass: 4 back-to-back beats a=3,b=5 -> out_valid one cycle after 4th beat, acc_out=60, ovf=0, beat_cnt=4.
REQ-028 SHALL pass: 4 beats a=-128,b=-128 -> running 16384, 32767 (ovf=1), 32767, 32767; result 32767 (0x7FFF), ovf=1.
REQ-029 SHALL pass: 4 beats a=-128,b=127 -> running -16256, -32512, -32768 (ovf=1), -32768; result 0x8000, ovf=1.
REQ-030 SHALL pass: beats a=-7,b=6 / 5,5 / -1,-1 / 0,100 with 2-cycle bubbles between -> result -16, ovf=0, bubbles not counted.
REQ-031 SHALL pass: out_ready low 5 cycles after result with in_valid=1, a=b=1 -> in_ready=0, result stable; on release next sum starts at 0 and 4 beats of 1*1 give 4.
REQ-032 SHALL pass: rst pulsed after 2 beats of 10*10 -> acc_out=0, beat_cnt=0, out_valid=0; next 4 beats 10*10 give 400.

Source files
------------

// File: rtl/signed_mac_acc.sv
// Signed 8x8 multiply-accumulate: sums LEN products with saturation, then
// presents the result under a valid/ready handshake until it is consumed.
module signed_mac_acc #(
  parameter int LEN   = 4,
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [7:0]       a,
  input  logic signed [7:0]       b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    ovf,
  output logic [7:0]              beat_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  localparam logic [7:0] LEN_C = 8'(LEN);

  // Returns {overflow_flag, saturated_sum}; the sum is formed one bit wider
  // than the accumulator so overflow shows up as disagreeing top bits.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic [15:0]      prod);
    logic [ACC_W:0] sum;
    sum = {acc[ACC_W-1], acc} + {{(ACC_W-15){prod[15]}}, prod};
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      if (sum[ACC_W]) begin
        sat_add = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        sat_add = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      sat_add = {1'b0, sum[ACC_W-1:0]};
    end
  endfunction

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic signed [15:0] prod_s;
  logic [ACC_W:0]     sat_s;
  logic [7:0]         cnt_inc_s;

  // Full-precision product, next accumulator value and next beat count.
  always_comb begin
    prod_s    = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
    sat_s     = sat_add(acc_q, prod_s);
    cnt_inc_s = cnt_q + 8'd1;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (in_valid) begin
          acc_d = sat_s[ACC_W-1:0];
          ovf_d = ovf_q | sat_s[ACC_W];
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == LEN_C) begin
            state_d     = S_HOLD;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
          end else begin
            state_d     = S_ACCUM;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_HOLD: begin
        // Consuming clears everything; the operand port stays closed this cycle.
        if (out_ready) begin
          state_d     = S_IDLE;
          acc_d       = {ACC_W{1'b0}};
          ovf_d       = 1'b0;
          cnt_d       = 8'd0;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d     = S_IDLE;
        acc_d       = {ACC_W{1'b0}};
        ovf_d       = 1'b0;
        cnt_d       = 8'd0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and output registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= {ACC_W{1'b0}};
      ovf_q       <= 1'b0;
      cnt_q       <= 8'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_signed_mac_acc.sv
// Randomized and directed bench for signed_mac_acc (LEN=4, ACC_W=16) against
// an integer-arithmetic reference model of the saturating sum.
module tb_signed_mac_acc;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [7:0]  a = 8'sd0;
  logic signed [7:0]  b = 8'sd0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] acc_out;
  logic               ovf;
  logic [7:0]         beat_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state
  int m_acc = 0;
  bit m_ovf = 1'b0;
  int m_cnt = 0;
  logic signed [15:0] exp_acc;

  signed_mac_acc #(.LEN(4), .ACC_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .ovf(ovf), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_acc = 0;
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  // Present one beat at the current falling edge; returns one cycle later with in_valid low.
  task automatic do_beat(input int x, input int y);
    in_valid = 1'b1;
    a = 8'(x);
    b = 8'(y);
    @(negedge clk);
    in_valid = 1'b0;
    m_acc = m_acc + x * y;
    if (m_acc > 32767) begin
      m_acc = 32767;
      m_ovf = 1'b1;
    end else if (m_acc < -32768) begin
      m_acc = -32768;
      m_ovf = 1'b1;
    end
    m_cnt++;
    exp_acc = m_acc[15:0];
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    total_cnt++;
    if ({out_valid, in_ready, ovf, beat_cnt, acc_out} !== {1'b0, 1'b1, 1'b0, 8'd0, 16'sd0}) begin
      $display("FAIL reset: valid=%0b ready=%0b ovf=%0b cnt=%0d acc=%0d, required 0 1 0 0 0",
               out_valid, in_ready, ovf, beat_cnt, acc_out);
    end else pass_cnt++;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      do_beat(3, 5);
      in_valid = (i < 3);
      total_cnt++;
      if (acc_out !== exp_acc || beat_cnt !== 8'(m_cnt) || out_valid !== (i == 3)) begin
        $display("FAIL basic beat%0d: acc=%0d cnt=%0d valid=%0b, required %0d %0d %0b",
                 i, acc_out, beat_cnt, out_valid, exp_acc, m_cnt, (i == 3));
      end else pass_cnt++;
    end
    total_cnt++;
    if (acc_out !== 16'sd60 || ovf !== 1'b0 || beat_cnt !== 8'd4 || in_ready !== 1'b0) begin
      $display("FAIL basic result: acc=%0d ovf=%0b cnt=%0d ready=%0b, required 60 0 4 0",
               acc_out, ovf, beat_cnt, in_ready);
    end else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    model_clear();
    total_cnt++;
    if (out_valid !== 1'b0 || acc_out !== 16'sd0 || beat_cnt !== 8'd0 || in_ready !== 1'b1) begin
      $display("FAIL consume: valid=%0b acc=%0d cnt=%0d ready=%0b, required 0 0 0 1",
               out_valid, acc_out, beat_cnt, in_ready);
    end else pass_cnt++;
  endtask

  task automatic test_saturation(input int x, input int y, input logic signed [15:0] final_acc);
    for (int i = 0; i < 4; i++) begin
      do_beat(x, y);
      total_cnt++;
      if (acc_out !== exp_acc || ovf !== m_ovf) begin
        $display("FAIL sat(%0d*%0d) beat%0d: acc=%0d ovf=%0b, required %0d %0b",
                 x, y, i, acc_out, ovf, exp_acc, m_ovf);
      end else pass_cnt++;
    end
    total_cnt++;
    if (acc_out !== final_acc || ovf !== 1'b1 || out_valid !== 1'b1) begin
      $display("FAIL sat result: acc=%0d ovf=%0b valid=%0b, required %0d 1 1",
               acc_out, ovf, out_valid, final_acc);
    end else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    model_clear();
    total_cnt++;
    if (ovf !== 1'b0 || out_valid !== 1'b0) begin
      $display("FAIL sat clear: ovf=%0b valid=%0b, required 0 0", ovf, out_valid);
    end else pass_cnt++;
  endtask

  task automatic test_bubbles();
    int xs[4] = '{-7, 5, -1, 0};
    int ys[4] = '{6, 5, -1, 100};
    for (int i = 0; i < 4; i++) begin
      do_beat(xs[i], ys[i]);
      if (i < 3) begin
        repeat (2) begin
          a = 8'($urandom);
          b = 8'($urandom);
          @(negedge clk);
        end
        total_cnt++;
        if (acc_out !== exp_acc || beat_cnt !== 8'(m_cnt)) begin
          $display("FAIL bubble after beat%0d: acc=%0d cnt=%0d, required %0d %0d",
                   i, acc_out, beat_cnt, exp_acc, m_cnt);
        end else pass_cnt++;
      end
    end
    total_cnt++;
    if (acc_out !== -16'sd16 || ovf !== 1'b0 || out_valid !== 1'b1 || beat_cnt !== 8'd4) begin
      $display("FAIL bubbles result: acc=%0d ovf=%0b valid=%0b cnt=%0d, required -16 0 1 4",
               acc_out, ovf, out_valid, beat_cnt);
    end else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    model_clear();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) do_beat(2, 3);
    in_valid = 1'b1;
    a = 8'sd1;
    b = 8'sd1;
    repeat (5) begin
      @(negedge clk);
      total_cnt++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || acc_out !== 16'sd24 || beat_cnt !== 8'd4) begin
        $display("FAIL hold: ready=%0b valid=%0b acc=%0d cnt=%0d, required 0 1 24 4",
                 in_ready, out_valid, acc_out, beat_cnt);
      end else pass_cnt++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    model_clear();
    total_cnt++;
    if (out_valid !== 1'b0 || acc_out !== 16'sd0 || beat_cnt !== 8'd0 || in_ready !== 1'b1) begin
      $display("FAIL release: valid=%0b acc=%0d cnt=%0d ready=%0b, required 0 0 0 1",
               out_valid, acc_out, beat_cnt, in_ready);
    end else pass_cnt++;
    for (int i = 0; i < 4; i++) do_beat(1, 1);
    total_cnt++;
    if (acc_out !== 16'sd4 || out_valid !== 1'b1) begin
      $display("FAIL after release: acc=%0d valid=%0b, required 4 1", acc_out, out_valid);
    end else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    model_clear();
  endtask

  task automatic test_mid_reset();
    do_beat(10, 10);
    do_beat(10, 10);
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    model_clear();
    total_cnt++;
    if (acc_out !== 16'sd0 || beat_cnt !== 8'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL mid reset: acc=%0d cnt=%0d valid=%0b ready=%0b, required 0 0 0 1",
               acc_out, beat_cnt, out_valid, in_ready);
    end else pass_cnt++;
    for (int i = 0; i < 4; i++) do_beat(10, 10);
    total_cnt++;
    if (acc_out !== 16'sd400 || out_valid !== 1'b1) begin
      $display("FAIL post reset sum: acc=%0d valid=%0b, required 400 1", acc_out, out_valid);
    end else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    model_clear();
  endtask

  task automatic test_random();
    for (int s = 0; s < 12; s++) begin
      for (int i = 0; i < 4; i++) begin
        do_beat($signed(8'($urandom)), $signed(8'($urandom)));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        total_cnt++;
        if (acc_out !== exp_acc || ovf !== m_ovf || beat_cnt !== 8'(m_cnt)) begin
          $display("FAIL random sum%0d beat%0d: acc=%0d ovf=%0b cnt=%0d, required %0d %0b %0d",
                   s, i, acc_out, ovf, beat_cnt, exp_acc, m_ovf, m_cnt);
        end else pass_cnt++;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b1 || acc_out !== exp_acc) begin
        $display("FAIL random result%0d: valid=%0b acc=%0d, required 1 %0d",
                 s, out_valid, acc_out, exp_acc);
      end else pass_cnt++;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      model_clear();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation(-128, -128, 16'sh7FFF);
    test_saturation(-128, 127, 16'sh8000);
    test_bubbles();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
